// File: rtl/fp96_mul_sched_pkg.sv
// Shared types for the FP96 multiplier scheduler: operand type, tag-pipe entry and flag bit positions.
package fp96_mul_sched_pkg;

    localparam int FP96_W   = 96;
    localparam int FLAGS_W  = 4;
    localparam int TAG_ID_W = 3;

    localparam int FLAG_UNDERFLOW = 0;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_INF       = 2;
    localparam int FLAG_SIGN_EXE  = 3;

    typedef logic [FP96_W-1:0] fp96_t;

    // The id field is sized for the largest supported requester count (8).
    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
        logic [2:0]          rm;
    } fp96_mul_tag_t;

    function automatic fp96_mul_tag_t make_tag(input logic v, input logic [TAG_ID_W-1:0] id,
                                               input logic [2:0] rm);
        fp96_mul_tag_t t;
        t.v  = v;
        t.id = id;
        t.rm = rm;
        return t;
    endfunction

endpackage

// File: rtl/fp96_mul_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping; pointer moves past each grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_any,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic [N-1:0]  upper_mask;
    logic [N-1:0]  upper_req;
    logic [N-1:0]  pick_src;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            assign upper_mask[gi] = (IW'(gi) >= ptr_reg);
            assign grant[gi]      = grant_any && (grant_id == IW'(gi));
        end
    endgenerate

    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    assign upper_req = req & upper_mask;
    assign pick_src  = (|upper_req) ? upper_req : req;

    always_comb begin
        grant_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick_src[i]) grant_id = IW'(i);
        end
    end

    assign grant_any = en && (|req);
    assign ptr_next  = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (grant_any) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/fp96_mul_sched.sv
// Shares one pipelined FP96 multiplier among NREQ requesters, tagging each op and steering results back in order.
module fp96_mul_sched
    import fp96_mul_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int LAT      = 12,
    parameter int RM_STAGE = LAT - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*FP96_W-1:0]     req_a,
    input  logic [NREQ*FP96_W-1:0]     req_b,
    input  logic [NREQ*3-1:0]          req_rm,
    output logic [NREQ-1:0]            res_valid,
    input  logic [NREQ-1:0]            res_ready,
    output logic [FP96_W-1:0]          res_o,
    output logic [FLAGS_W-1:0]         res_flags,
    output logic                       mul_ce,
    output logic [FP96_W-1:0]          mul_a,
    output logic [FP96_W-1:0]          mul_b,
    output logic [2:0]                 mul_rm,
    input  logic [FP96_W-1:0]          mul_o,
    input  logic [FLAGS_W-1:0]         mul_flags,
    output logic [$clog2(LAT+1)-1:0]   inflight
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(LAT + 1);

    fp96_mul_tag_t    s_reg [LAT];
    logic [CNT_W-1:0] inflight_reg;

    logic             head_v;
    logic [ID_W-1:0]  head_id;
    logic             consume;
    logic [NREQ-1:0]  grant;
    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    logic [2:0]       issue_rm;

    assign head_v  = s_reg[LAT-1].v;
    assign head_id = s_reg[LAT-1].id[ID_W-1:0];

    // A valid head whose owner is not ready freezes the multiplier and the tag pipe together.
    assign mul_ce  = !(head_v && !res_ready[head_id]);
    assign consume = head_v && res_ready[head_id];

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (mul_ce && rst_n),
        .req       (req_valid),
        .grant     (grant),
        .grant_any (grant_any),
        .grant_id  (grant_id)
    );

    assign req_ready = grant;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_res
            assign res_valid[gi] = rst_n && head_v && (head_id == ID_W'(gi));
        end
    endgenerate

    assign res_o     = mul_o;
    assign res_flags = mul_flags;

    assign mul_a    = grant_any ? req_a[int'(grant_id)*FP96_W +: FP96_W] : '0;
    assign mul_b    = grant_any ? req_b[int'(grant_id)*FP96_W +: FP96_W] : '0;
    assign issue_rm = grant_any ? req_rm[int'(grant_id)*3 +: 3] : 3'b000;

    // The rounding register inside the multiplier samples the op sitting at RM_STAGE.
    assign mul_rm = s_reg[RM_STAGE].v ? s_reg[RM_STAGE].rm : 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                s_reg[k] <= '0;
            end
        end else if (mul_ce) begin
            s_reg[0] <= make_tag(grant_any, TAG_ID_W'(grant_id), issue_rm);
            for (int k = 1; k < LAT; k++) begin
                s_reg[k] <= s_reg[k-1];
            end
        end
    end

    // Issue only happens with mul_ce high and consume implies mul_ce, so no extra qualification is needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_reg <= '0;
        end else begin
            case ({grant_any, consume})
                2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
                2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    assign inflight = inflight_reg;

endmodule
